width_gearbox: RTL and testbench

- Parametrised gearbox that packs a stream of IN_W-bit beats into OUT_W-bit words. The ratio does not need to be an integer (default 24->128).
- Adds valid/ready handshakes on both sides, so the downstream can apply backpressure.
- Optional flush emits a final partial word.
- Sits between narrow sample sources and wide bus/FIFO writers.

---
 rtl/gearbox_pkg.sv | 21 ++
 rtl/width_gearbox.sv | 124 ++++++++++++
 tb/tb_width_gearbox.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for width_gearbox: default widths and fill-counter sizing.
package gearbox_pkg;

    localparam int unsigned DEF_IN_W  = 24;
    localparam int unsigned DEF_OUT_W = 128;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v > (32'd1 << i)) r = i + 1;
        end
        return r;
    endfunction

    // Fill counter must hold fill+IN_W, which peaks just below OUT_W+IN_W.
    function automatic int unsigned cnt_width(input int unsigned in_w, input int unsigned out_w);
        return clog2(out_w + in_w + 1);
    endfunction

endpackage

// File: rtl/width_gearbox.sv
// Packs IN_W-bit beats into OUT_W-bit words, earliest bit at the MSB, with valid/ready on both sides.
// Define GEARBOX_FLUSH_EN to add flush_req/out_last/flush_done for emitting a final partial word.
module width_gearbox
    import gearbox_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef GEARBOX_FLUSH_EN
    input  logic             flush_req,
    output logic             out_last,
    output logic             flush_done,
`endif
    output logic [OUT_W-1:0] out_data
);

    localparam int unsigned CNT_W  = cnt_width(IN_W, OUT_W);
    localparam int unsigned WIDE_W = OUT_W + IN_W;

    if (IN_W == 0 || IN_W >= OUT_W) begin : g_bad_params
        $error("width_gearbox: require 1 <= IN_W < OUT_W");
    end

    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [OUT_W-1:0]  buf_q, buf_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  sum_c, rem_c;
    logic [WIDE_W-1:0] wide_c;
    logic              completes_c, out_free_c, accept_c;
`ifdef GEARBOX_FLUSH_EN
    logic              out_last_q, out_last_d;
    logic              flush_done_q, flush_done_d;
`endif

    // Remainder buffer is right-justified: the low fill_q bits are valid, the rest stay zero.
    always_comb begin
        sum_c       = fill_q + CNT_W'(IN_W);
        completes_c = (sum_c >= CNT_W'(OUT_W));
        rem_c       = sum_c - CNT_W'(OUT_W);
        out_free_c  = !out_valid_q || out_ready;
        in_ready    = !(completes_c && !out_free_c);
        accept_c    = in_valid && in_ready;
        wide_c      = {buf_q, in_data};
    end

    always_comb begin
        fill_d       = fill_q;
        buf_d        = buf_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !out_ready;
`ifdef GEARBOX_FLUSH_EN
        out_last_d   = out_last_q && out_valid_q && !out_ready;
        flush_done_d = 1'b0;
`endif
        if (accept_c) begin
            if (completes_c) begin
                // Top OUT_W of the valid bits form the word; the low rem_c bits of the beat carry over.
                out_data_d  = OUT_W'(wide_c >> rem_c);
                out_valid_d = 1'b1;
                fill_d      = rem_c;
                buf_d       = OUT_W'(in_data & ~({IN_W{1'b1}} << rem_c));
`ifdef GEARBOX_FLUSH_EN
                out_last_d  = 1'b0;
`endif
            end else begin
                fill_d = sum_c;
                buf_d  = OUT_W'(wide_c);
            end
        end
`ifdef GEARBOX_FLUSH_EN
        // Blocking on flush_done_q keeps a held request from re-triggering in the pulse cycle.
        if (!in_valid && flush_req && !flush_done_q) begin
            if (fill_q == '0) begin
                flush_done_d = 1'b1;
            end else if (out_free_c) begin
                out_data_d   = buf_q << (CNT_W'(OUT_W) - fill_q);
                out_valid_d  = 1'b1;
                out_last_d   = 1'b1;
                fill_d       = '0;
                buf_d        = '0;
                flush_done_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q       <= '0;
            buf_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
`ifdef GEARBOX_FLUSH_EN
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
`endif
        end else begin
            fill_q       <= fill_d;
            buf_q        <= buf_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
`ifdef GEARBOX_FLUSH_EN
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
`ifdef GEARBOX_FLUSH_EN
    assign out_last   = out_last_q;
    assign flush_done = flush_done_q;
`endif

endmodule

// File: tb/tb_width_gearbox.sv
// Scoreboard bench for width_gearbox: default 24->128 instance plus an 8->20 instance.
module tb_width_gearbox;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    localparam logic [127:0] W1 = 128'h00000100000200000300000400000500;
    localparam logic [127:0] W2 = 128'h000600000700000800000900000A0000;
    localparam logic [127:0] W3 = 128'h0B00000C00000D00000E00000F000010;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [23:0]  in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
`ifdef GEARBOX_FLUSH_EN
    logic         flush_req = 1'b0;
    logic         out_last;
    logic         flush_done;
`endif

    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic [7:0]   s_in_data = '0;
    logic         s_out_valid;
    logic         s_out_ready = 1'b1;
    logic [19:0]  s_out_data;
`ifdef GEARBOX_FLUSH_EN
    logic         s_out_last;
    logic         s_flush_done;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    exp_t         exp_q[$];
    logic [19:0]  exp_s_q[$];

    always #5 clk = ~clk;

    width_gearbox #(.IN_W(24), .OUT_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef GEARBOX_FLUSH_EN
        .flush_req(flush_req), .out_last(out_last), .flush_done(flush_done),
`endif
        .out_data(out_data)
    );

    width_gearbox #(.IN_W(8), .OUT_W(20)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
`ifdef GEARBOX_FLUSH_EN
        .flush_req(1'b0), .out_last(s_out_last), .flush_done(s_flush_done),
`endif
        .out_data(s_out_data)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a word is handed off.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_data, '0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
`ifdef GEARBOX_FLUSH_EN
                check("out_last", 128'(out_last), 128'(e.last));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            if (exp_s_q.size() == 0) begin
                check("s_unexpected_word", 128'(s_out_data), '0);
            end else begin
                logic [19:0] e;
                e = exp_s_q.pop_front();
                check("s_out_data", 128'(s_out_data), 128'(e));
            end
        end
    end

    task automatic push_beat(input logic [23:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_s(input logic [7:0] d);
        int n;
        n = 0;
        s_in_valid = 1'b1;
        s_in_data  = d;
        #1;
        while (!s_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_in_ready) check("s_in_ready_timeout", 128'(s_in_ready), 128'(1));
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    task automatic push_expected_stream();
        exp_q.push_back('{W1, 1'b0});
        exp_q.push_back('{W2, 1'b0});
        exp_q.push_back('{W3, 1'b0});
    endtask

    task automatic run_stream(input string name);
        push_expected_stream();
        for (int b = 1; b <= 16; b++) begin
            push_beat(24'(b));
            check(name, 128'(out_valid), 128'(b == 6 || b == 11 || b == 16));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        check("rst_out_valid", 128'(out_valid), '0);
        check("rst_out_data", out_data, '0);
`ifdef GEARBOX_FLUSH_EN
        check("rst_out_last", 128'(out_last), '0);
        check("rst_flush_done", 128'(flush_done), '0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous stream, out_ready held high.
        out_ready = 1'b1;
        run_stream("stream_latency");

        // Backpressure: stall downstream, beat 11 must wait.
        push_expected_stream();
        out_ready = 1'b0;
        for (int b = 1; b <= 10; b++) push_beat(24'(b));
        in_valid = 1'b1;
        in_data  = 24'd11;
        #1;
        check("bp_in_ready_low", 128'(in_ready), '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 128'(out_valid), 128'(1));
            check("bp_hold_data", out_data, W1);
            check("bp_in_ready_held", 128'(in_ready), '0);
        end
        out_ready = 1'b1;
        push_beat(24'd11);
        check("bp_word2_loaded", out_data, W2);
        for (int b = 12; b <= 16; b++) push_beat(24'(b));
        @(posedge clk); #1;

        // Gapped input: idle cycle between beats.
        push_expected_stream();
        for (int b = 1; b <= 16; b++) begin
            push_beat(24'(b));
            check("gap_latency", 128'(out_valid), 128'(b == 6 || b == 11 || b == 16));
            @(posedge clk); #1;
            check("gap_idle_valid", 128'(out_valid), '0);
        end

`ifdef GEARBOX_FLUSH_EN
        // Flush of a 72-bit remainder, then a flush with nothing buffered.
        begin
            int n;
            exp_q.push_back('{128'hAAAAAABBBBBBCCCCCC00000000000000, 1'b1});
            push_beat(24'hAAAAAA);
            push_beat(24'hBBBBBB);
            push_beat(24'hCCCCCC);
            flush_req = 1'b1;
            n = 0;
            #1;
            while (!flush_done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("flush_done_pulse", 128'(flush_done), 128'(1));
            check("flush_out_valid", 128'(out_valid), 128'(1));
            check("flush_out_last", 128'(out_last), 128'(1));
            flush_req = 1'b0;
            @(posedge clk); #1;
            check("flush_done_single", 128'(flush_done), '0);
            flush_req = 1'b1;
            n = 0;
            while (!flush_done && n < 20) begin
                @(posedge clk); #1;
                n++;
                check("empty_flush_no_word", 128'(out_valid), '0);
            end
            check("empty_flush_done", 128'(flush_done), 128'(1));
            flush_req = 1'b0;
            @(posedge clk); #1;
        end
`endif

        // Reset with a pending word and a partial remainder.
        out_ready = 1'b0;
        for (int b = 1; b <= 7; b++) push_beat(24'(b));
        check("pre_reset_pending", 128'(out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), '0);
        check("mid_rst_out_data", out_data, '0);
`ifdef GEARBOX_FLUSH_EN
        check("mid_rst_out_last", 128'(out_last), '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_stream("post_reset_latency");

        // Narrow instance: 8 -> 20.
        exp_s_q.push_back(20'h12345);
        exp_s_q.push_back(20'h6789A);
        push_s(8'h12);
        push_s(8'h34);
        push_s(8'h56);
        check("s_word1_latency", 128'(s_out_valid), 128'(1));
        push_s(8'h78);
        push_s(8'h9A);
        check("s_word2_latency", 128'(s_out_valid), 128'(1));

        repeat (4) @(posedge clk);
        #1;
        check("main_scoreboard_empty", 128'(exp_q.size()), '0);
        check("small_scoreboard_empty", 128'(exp_s_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
